// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - sequential signed fixed-point divider with saturation
//
// Computes quotient = A / B on signed Q-format operands (WIDTH bits, FRAC_BITS
// fractional) using an unsigned restoring divider on the magnitudes, one
// quotient bit per clock. Latency is constant: WIDTH+FRAC_BITS iterations plus
// one finish cycle, whether or not B is zero.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       start pulse, only honoured while idle
//   A, B         signed dividend / divisor, captured on the accepting edge
//   quotient     signed result, updated only on the finish edge
//   busy         high while a division is in flight
//   done         one-cycle pulse when quotient is valid
//   saturated    result was clamped (held until the next finish)
//   div_by_zero  divisor was zero (held until the next finish)

module fixed_point_divider #(
   parameter int WIDTH     = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] quotient,
   output logic             busy,
   output logic             done,
   output logic             saturated,
   output logic             div_by_zero
);

   localparam int N  = WIDTH + FRAC_BITS;
   localparam int CW = $clog2(N + 1);

   localparam logic [CW-1:0]    N_CNT   = CW'(N);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   // Magnitude limits widened to the full N-bit quotient accumulator.
   localparam logic [N-1:0]     POS_LIM = {{(FRAC_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [N-1:0]     NEG_LIM = POS_LIM + 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      FINISH
   } state_t;

   state_t state;
   state_t state_next;

   logic             sign;
   logic             a_neg;
   logic             zero_flag;
   logic [WIDTH-1:0] mag_b;
   logic [N-1:0]     dvd;
   logic [WIDTH:0]   rem;
   logic [N-1:0]     quot_acc;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] res_q;
   logic             res_sat;

   // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1),
   // which still fits because the magnitude is treated as unsigned.
   assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
   assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

   // Restoring step: shift in the next dividend bit, trial-subtract the divisor.
   // A borrow out of the widened difference means the trial failed.
   assign shifted = {rem, dvd[N-1]};
   assign diff    = shifted - {2'b00, mag_b};
   assign ge      = ~diff[WIDTH+1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = DIVIDE;
         DIVIDE:  if (count == CNT_ONE) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      res_q   = quot_acc[WIDTH-1:0];
      res_sat = 1'b0;
      if (zero_flag) begin
         res_q   = a_neg ? MIN_NEG : MAX_POS;
         res_sat = 1'b1;
      end else if (!sign && (quot_acc > POS_LIM)) begin
         res_q   = MAX_POS;
         res_sat = 1'b1;
      end else if (sign && (quot_acc > NEG_LIM)) begin
         res_q   = MIN_NEG;
         res_sat = 1'b1;
      end else if (sign) begin
         res_q   = -quot_acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quotient    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         saturated   <= 1'b0;
         div_by_zero <= 1'b0;
         sign        <= 1'b0;
         a_neg       <= 1'b0;
         zero_flag   <= 1'b0;
         mag_b       <= '0;
         dvd         <= '0;
         rem         <= '0;
         quot_acc    <= '0;
         count       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  sign      <= A[WIDTH-1] ^ B[WIDTH-1];
                  a_neg     <= A[WIDTH-1];
                  zero_flag <= (B == '0);
                  mag_b     <= b_mag;
                  dvd       <= {a_mag, {FRAC_BITS{1'b0}}};
                  rem       <= '0;
                  quot_acc  <= '0;
                  count     <= N_CNT;
                  busy      <= 1'b1;
               end
            end
            DIVIDE: begin
               rem      <= ge ? diff[WIDTH:0] : shifted[WIDTH:0];
               quot_acc <= {quot_acc[N-2:0], ge};
               dvd      <= {dvd[N-2:0], 1'b0};
               count    <= count - 1'b1;
            end
            FINISH: begin
               quotient    <= res_q;
               saturated   <= res_sat;
               div_by_zero <= zero_flag;
               busy        <= 1'b0;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider, quotient = A / B, 2's complement in and out.
- Fills the inverse-arithmetic slot alongside the saturating adder.
- Same enable/done pulse handshake and the same saturation rule (clamp to 0x7FFF / 0x8000).
- Used in the spectrum/normalisation path where a multi-cycle latency is acceptable and a combinational divider is not.

Parameters:
- WIDTH, 16: operand and quotient width, signed 2's complement.
- FRAC_BITS, 8: fractional bits of the Q format. Operands and quotient share the format; with defaults 1.0 = 0x0100.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  start pulse; sampled only when idle.
- A  input  WIDTH  signed dividend, captured on the accepted enable edge.
- B  input  WIDTH  signed divisor, captured on the accepted enable edge.
- quotient  output  WIDTH  signed result; updated only on the finish edge, held otherwise.
- busy  output  1  high while a division is in flight.
- done  output  1  one-cycle pulse when quotient is valid.
- saturated  output  1  result was clamped; valid with done, held until the next finish.
- div_by_zero  output  1  B was zero; valid with done, held until the next finish.

Behaviour:
- Reset (reset=0, async): state IDLE; quotient=0, busy=0, done=0, saturated=0, div_by_zero=0; iteration counter and remainder cleared.
- Releasing reset mid-division: the operation is abandoned. No done pulse follows.
- States: IDLE -> DIVIDE -> FINISH -> IDLE.
- IDLE:
  - On an edge with enable=1: capture sign = A[MSB]^B[MSB].
  - Capture magA=|A| and magB=|B| as unsigned WIDTH-bit values. |0x8000| = 0x8000 must not overflow.
  - Set zero flag = (B==0), clear the remainder, set counter N = WIDTH+FRAC_BITS (24 by default).
  - Set busy=1 and go to DIVIDE.
- DIVIDE:
  - Unsigned restoring division of dividend {magA, FRAC_BITS zeros} (N bits) by magB.
  - One quotient bit per edge, MSB first. Remainder is WIDTH+1 bits so shift-then-compare cannot overflow.
  - After N edges, go to FINISH.
  - With B==0 the iterations still run and their result is discarded, so latency is constant.
- FINISH (one edge): register quotient and flags, busy<=0, done<=1, go to IDLE. Result rules:
  - B==0: quotient=0x8000 if A<0, else 0x7FFF (including A==0). div_by_zero=1, saturated=1.
  - sign=0 and magnitude > 2^(WIDTH-1)-1: quotient=0x7FFF, saturated=1.
  - sign=1 and magnitude > 2^(WIDTH-1): quotient=0x8000, saturated=1.
  - Otherwise quotient = sign ? -magnitude : magnitude, saturated=0.
  - A zero magnitude yields 0x0000 regardless of sign.
- Rounding is truncation toward zero.
- Latency: enable sampled on edge k -> done high after edge k+N+1 (k+25 by default). done drops on the following edge.
- enable while busy=1 is ignored: no restart, no operand recapture.
- enable is accepted in the same cycle done is high (state is IDLE). Back-to-back throughput is one result per N+2 cycles.
- A and B need only be stable on the accepting edge.

Test Plan:
- Latency and basic quotient: A=0x0300 (3.0), B=0x0200 (2.0), enable pulse -> quotient=0x0180, done a single-cycle pulse exactly 25 edges after the sampling edge, busy high for those 25 cycles, saturated=0.
- Signs and truncation:
  - A=0xFD00, B=0x0200 -> 0xFE80.
  - A=0x0300, B=0xFE00 -> 0xFE80.
  - A=0x0001, B=0x0300 -> 0x0000.
  - A=0xFFFF, B=0x0300 -> 0x0000, not 0xFFFF.
- Saturation boundaries:
  - A=0x7F00, B=0x0080 -> 0x7FFF, saturated=1.
  - A=0x8000, B=0x0100 -> 0x8000, saturated=0.
  - A=0x8000, B=0xFF00 -> 0x7FFF, saturated=1.
- Divide by zero (B=0x0000), each with div_by_zero=1, saturated=1 and done at the normal latency:
  - A=0x0100 -> 0x7FFF.
  - A=0xFF00 -> 0x8000.
  - A=0x0000 -> 0x7FFF.
- Handshake:
  - Assert enable again with A=0x0100, B=0x0100 at cycle 5 of a running 3.0/2.0 division -> ignored, result still 0x0180.
  - Assert enable in the done cycle with A=0x0100, B=0x0400 -> second result 0x0040 exactly 25 edges later.
- Async reset: pull reset low mid-DIVIDE between clock edges -> outputs zero immediately. No done pulse after release. A fresh enable produces the correct result.
